frequency_multiplier: RTL and testbench
=======================================

Name: frequency_multiplier

Overview:
- Digital rate multiplier (phase-accumulator NCO) clocked by `clk_in`.
- Produces a square-wave `clk_out` whose average frequency is f_in × MULT / 2^ACC_WIDTH.
- Sits between the system reference clock and downstream logic that needs a programmable-ratio clock/strobe.
- `clk_out` is driven directly from a flip-flop, so it is glitch-free.

Parameters:
- ACC_WIDTH, 16, accumulator width in bits (legal range 4..32).
- MULT, 16384, phase increment added every `clk_in` rising edge. Legal range 0..2^(ACC_WIDTH-1). An elaboration-time error (`$error`/`$fatal`) fires if MULT is out of range.

Ports:
- clk_in  input  1  reference clock; sole clock of the block.
- reset   input  1  asynchronous, active-high reset.
- clk_out output 1  synthesized clock = MSB of phase accumulator.

Behaviour:
- State: one ACC_WIDTH-bit register `acc`.
  - Reset value 0.
  - No other state; no FSM.
- Reset (async, active-high):
  - While `reset`=1: `acc`=0 and `clk_out`=0 immediately, independent of `clk_in`.
  - Reset asserted mid-operation forces `clk_out` low at once, even if it is mid-high-phase.
- Reset release:
  - The first `clk_in` rising edge with `reset`=0 performs the first update.
  - No extra synchronisation stage inside the block; release timing is the integrator's responsibility.
- Update at every `clk_in` rising edge while not in reset:
  - acc <= (acc + MULT) mod 2^ACC_WIDTH.
  - Wrap-around is natural unsigned overflow; the carry is discarded.
- Output:
  - clk_out = acc[ACC_WIDTH-1], taken directly from the register, with no combinational logic after the flop.
  - clk_out changes only on `clk_in` rising edges, with a latency of 1 edge after the add.
- Frequency:
  - Over any window of 2^ACC_WIDTH `clk_in` cycles, `clk_out` has exactly MULT rising edges.
  - When 2^ACC_WIDTH/MULT is an integer, the period is constant and equal to that value.
  - Otherwise the period alternates between floor and ceil of 2^ACC_WIDTH/MULT `clk_in` cycles (bounded jitter of 1 input cycle).
- Boundary conditions:
  - MULT=0: `clk_out` stays 0 forever.
  - MULT=2^(ACC_WIDTH-1): `clk_out` toggles every `clk_in` edge, giving f_in/2 (the maximum).
- Duty cycle: 50% when 2^ACC_WIDTH/MULT is an even integer; otherwise within ±1 `clk_in` cycle of 50%.
- Defaults (ACC_WIDTH=16, MULT=16384):
  - `acc` sequence: 16384, 32768, 49152, 0, ...
  - `clk_out` sequence: 0, 1, 1, 0, ...
  - `clk_out` period = 4 `clk_in` cycles, duty 50%.
  - First `clk_out` rise occurs at the 2nd `clk_in` rising edge after reset release.

Test Plan:
- Defaults, 10 ns `clk_in`, `reset` high 0–2 ns:
  - `clk_out` rises at 15, 55, 95 ns.
  - `clk_out` falls at 35, 75 ns.
  - `clk_out` stays 0 before 15 ns.
- MULT=32768, ACC_WIDTH=16:
  - `clk_out` toggles on every `clk_in` rising edge, starting with a rise on the 1st edge after reset.
  - Period = 20 ns.
- MULT=12288 (ratio 3/16):
  - Exactly 3 `clk_out` rising edges per 16 `clk_in` cycles.
  - Spacing between rises is 5 or 6 cycles only.
  - The pattern repeats every 16 cycles.
- MULT=0: run 1000 cycles -> `clk_out` constantly 0.
- Reset mid-operation:
  - Assert `reset` between `clk_in` edges while `clk_out`=1 -> `clk_out` goes 0 immediately, without waiting for a clock edge.
  - After release, the sequence restarts as in scenario 1 (first rise on the 2nd edge).
- Wrap-around with ACC_WIDTH=4, MULT=3:
  - `acc` sequence: 3, 6, 9, 12, 15, 2, 5, ...
  - `clk_out` sequence: 0, 0, 1, 1, 1, 0, 0, ...
  - 3 rises per 16 cycles.

Source files
------------

// File: rtl/frequency_multiplier.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// frequency_multiplier
//
// Digital rate multiplier built as a phase-accumulator NCO. Every rising
// edge of clk_in adds MULT to an ACC_WIDTH-bit accumulator. The accumulator
// MSB is the synthesized clock. Its average frequency is
// f_in * MULT / 2^ACC_WIDTH.
//
// Parameters:
//   ACC_WIDTH - accumulator width in bits, legal range 4..32
//   MULT      - phase increment per clk_in edge, legal range 0..2^(ACC_WIDTH-1)
//
// Ports:
//   clk_in  - reference clock, the only clock of the block
//   reset   - asynchronous, active-high reset; clears the accumulator
//   clk_out - synthesized clock, taken straight from the accumulator MSB flop
// ---------------------------------------------------------------------------
module frequency_multiplier #(
  parameter int          ACC_WIDTH = 16,
  parameter int unsigned MULT      = 16384
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out
);

  // Parameter sanity checks. Above half scale, the MSB can no longer toggle
  // once per increment, so the output would alias to a lower frequency.
  if (ACC_WIDTH < 4 || ACC_WIDTH > 32) begin : g_bad_width
    $error("frequency_multiplier: ACC_WIDTH=%0d outside 4..32", ACC_WIDTH);
  end

  if (64'(MULT) > (64'd1 << (ACC_WIDTH - 1))) begin : g_bad_mult
    $error("frequency_multiplier: MULT=%0d exceeds 2^(ACC_WIDTH-1)", MULT);
  end

  localparam logic [ACC_WIDTH-1:0] phase_inc = ACC_WIDTH'(MULT);

  logic [ACC_WIDTH-1:0] acc;

  // The carry out of the add is dropped on purpose. Wrapping modulo
  // 2^ACC_WIDTH keeps the long-run edge count exact, with no drift.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= acc + phase_inc;
    end
  end

  // No logic sits after the flop, so clk_out is glitch-free.
  assign clk_out = acc[ACC_WIDTH-1];

endmodule

// File: tb/tb_frequency_multiplier.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_frequency_multiplier
//
// Five instances with different ACC_WIDTH/MULT settings share one clock and
// one reset. The reference model is the closed form: after n clk_in edges
// since reset, the phase is (n*MULT) mod 2^W, and the output is high when
// that phase is in the upper half.
// ---------------------------------------------------------------------------
module tb_frequency_multiplier;

  logic clk_in;
  logic reset;
  logic out_def, out_max, out_316, out_zero, out_w4;
  logic [4:0] outs;

  localparam int              WID[5] = '{16, 16, 16, 16, 4};
  localparam longint unsigned MUL[5] = '{16384, 32768, 12288, 0, 3};

  int checks = 0;
  int passed = 0;
  longint unsigned n_edges;
  longint rise_def[$];
  longint fall_def[$];

  frequency_multiplier #(.ACC_WIDTH(16), .MULT(16384)) u_def
    (.clk_in(clk_in), .reset(reset), .clk_out(out_def));
  frequency_multiplier #(.ACC_WIDTH(16), .MULT(32768)) u_max
    (.clk_in(clk_in), .reset(reset), .clk_out(out_max));
  frequency_multiplier #(.ACC_WIDTH(16), .MULT(12288)) u_316
    (.clk_in(clk_in), .reset(reset), .clk_out(out_316));
  frequency_multiplier #(.ACC_WIDTH(16), .MULT(0)) u_zero
    (.clk_in(clk_in), .reset(reset), .clk_out(out_zero));
  frequency_multiplier #(.ACC_WIDTH(4), .MULT(3)) u_w4
    (.clk_in(clk_in), .reset(reset), .clk_out(out_w4));

  assign outs = {out_w4, out_zero, out_316, out_max, out_def};

  // 10 ns reference clock, first rising edge at 5 ns
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Number of clk_in rising edges seen since the last reset release
  always @(posedge clk_in or posedge reset) begin
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  always @(posedge out_def) rise_def.push_back($time);
  always @(negedge out_def) fall_def.push_back($time);

  // Expected clk_out after n edges for a given width and increment
  function automatic logic model_out(input int w, input longint unsigned mult,
                                     input longint unsigned n);
    longint unsigned modulus;
    longint unsigned phase;
    modulus = 64'd1 << w;
    phase   = (n * mult) % modulus;
    return (phase >= (modulus >> 1));
  endfunction

  // Pulse reset between two clock edges, releasing before the next rise
  task automatic apply_reset();
    @(negedge clk_in);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (outs[k] !== 1'b0)
        $display("[TB] FAIL reset_inst%0d: clk_out=%b expected 0", k, outs[k]);
      else passed++;
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_default_timing();
    longint exp_rise[3] = '{15, 55, 95};
    longint exp_fall[2] = '{35, 75};
    logic exp;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      exp = model_out(16, 16384, n_edges);
      checks++;
      if (out_def !== exp)
        $display("[TB] FAIL default_seq t=%0t: clk_out=%b expected %b", $time, out_def, exp);
      else passed++;
    end
    checks++;
    if (rise_def.size() < 3 || fall_def.size() < 2) begin
      $display("[TB] FAIL default_edges: rises=%0d falls=%0d expected >=3 and >=2",
               rise_def.size(), fall_def.size());
    end else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rise_def[i] != exp_rise[i])
          $display("[TB] FAIL default_rise%0d: at %0d ns expected %0d ns", i, rise_def[i], exp_rise[i]);
        else passed++;
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (fall_def[i] != exp_fall[i])
          $display("[TB] FAIL default_fall%0d: at %0d ns expected %0d ns", i, fall_def[i], exp_fall[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_max_rate();
    logic exp;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      exp = n_edges[0];
      checks++;
      if (out_max !== exp)
        $display("[TB] FAIL max_rate edge%0d: clk_out=%b expected %b", n_edges, out_max, exp);
      else passed++;
    end
  endtask

  task automatic test_ratio_3_16();
    logic s[48];
    int   rise_idx[$];
    int   win_a, win_b, bad_gap, bad_period;
    logic exp;
    apply_reset();
    for (int i = 0; i < 48; i++) begin
      @(negedge clk_in);
      s[i] = out_316;
      exp  = model_out(16, 12288, n_edges);
      checks++;
      if (out_316 !== exp)
        $display("[TB] FAIL ratio_seq edge%0d: clk_out=%b expected %b", n_edges, out_316, exp);
      else passed++;
    end
    win_a = 0; win_b = 0;
    for (int i = 1; i < 48; i++) begin
      if (s[i-1] == 1'b0 && s[i] == 1'b1) begin
        rise_idx.push_back(i);
        if (i < 17) win_a++;
        else if (i < 33) win_b++;
      end
    end
    checks++;
    if (win_a != 3) $display("[TB] FAIL ratio_window_a: rises=%0d expected 3", win_a);
    else passed++;
    checks++;
    if (win_b != 3) $display("[TB] FAIL ratio_window_b: rises=%0d expected 3", win_b);
    else passed++;
    bad_gap = 0;
    for (int i = 1; i < rise_idx.size(); i++) begin
      if ((rise_idx[i] - rise_idx[i-1]) != 5 && (rise_idx[i] - rise_idx[i-1]) != 6)
        bad_gap++;
    end
    checks++;
    if (bad_gap != 0 || rise_idx.size() < 6)
      $display("[TB] FAIL ratio_spacing: bad_gaps=%0d rises=%0d expected 0 bad, >=6 rises",
               bad_gap, rise_idx.size());
    else passed++;
    bad_period = 0;
    for (int i = 0; i < 32; i++) if (s[i] !== s[i+16]) bad_period++;
    checks++;
    if (bad_period != 0) $display("[TB] FAIL ratio_period16: mismatched samples=%0d expected 0", bad_period);
    else passed++;
  endtask

  task automatic test_zero();
    int ones;
    apply_reset();
    ones = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk_in);
      if (out_zero !== 1'b0) ones++;
    end
    checks++;
    if (ones != 0) $display("[TB] FAIL zero_mult: high samples=%0d expected 0", ones);
    else passed++;
  endtask

  task automatic test_wrap_w4();
    logic exp_seq[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic prev;
    int   rises;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      checks++;
      if (out_w4 !== exp_seq[i])
        $display("[TB] FAIL wrap_w4_seq%0d: clk_out=%b expected %b", i, out_w4, exp_seq[i]);
      else passed++;
    end
    prev  = exp_seq[6];
    rises = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (prev == 1'b0 && out_w4 == 1'b1) rises++;
      prev = out_w4;
    end
    checks++;
    if (rises != 3) $display("[TB] FAIL wrap_w4_rises: rises=%0d expected 3", rises);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int waited;
    waited = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk_in);
    @(negedge clk_in);
    while (out_def !== 1'b1 && waited < 20) begin
      @(negedge clk_in);
      waited++;
    end
    checks++;
    if (out_def !== 1'b1) begin
      $display("[TB] FAIL mid_reset_wait: clk_out=%b expected 1 within 20 cycles", out_def);
    end else begin
      passed++;
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (outs[k] !== 1'b0)
          $display("[TB] FAIL mid_reset_inst%0d: clk_out=%b expected 0", k, outs[k]);
        else passed++;
      end
      #1 reset = 1'b0;
      @(negedge clk_in);
      checks++;
      if (out_def !== 1'b0) $display("[TB] FAIL mid_reset_edge1: clk_out=%b expected 0", out_def);
      else passed++;
      @(negedge clk_in);
      checks++;
      if (out_def !== 1'b1) $display("[TB] FAIL mid_reset_edge2: clk_out=%b expected 1", out_def);
      else passed++;
    end
  endtask

  task automatic test_random_runs();
    int  a, nonzero;
    logic exp;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(5, 40)) begin
        @(negedge clk_in);
        for (int k = 0; k < 5; k++) begin
          exp = model_out(WID[k], MUL[k], n_edges);
          checks++;
          if (outs[k] !== exp)
            $display("[TB] FAIL random_run%0d_inst%0d edge%0d: clk_out=%b expected %b",
                     r, k, n_edges, outs[k], exp);
          else passed++;
        end
      end
      @(negedge clk_in);
      a = $urandom_range(1, 3);
      #(a) reset = 1'b1;
      #1;
      nonzero = 0;
      for (int k = 0; k < 5; k++) if (outs[k] !== 1'b0) nonzero++;
      checks++;
      if (nonzero != 0) $display("[TB] FAIL random_reset%0d: high outputs=%0d expected 0", r, nonzero);
      else passed++;
      #(3 - a) reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_default_timing();
    test_max_rate();
    test_ratio_3_16();
    test_zero();
    test_wrap_w4();
    test_mid_reset();
    test_random_runs();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
